// File: rtl/zdos_trap.sv
// rtl/zdos_trap.sv - Z80 bus-cycle classifier producing DOS enter/exit, VG93 and system-port strobes.
// One classification per bus cycle, taken on the IDLE exit edge; every strobe is a registered one-fclk pulse.
module zdos_trap #(
  parameter logic [7:0] TRAP_HI  = 8'h3D,
  parameter logic [7:0] SYS_PORT = 8'hFF
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic [15:0] a,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        dos,
  input  logic        romnram,
  input  logic        rom_basic,
  input  logic        trap_en,
  output logic        dos_turn_on,
  output logic        dos_turn_off,
  output logic        vg_rdwr_fclk,
  output logic [1:0]  vg_a,
  output logic        sys_wr,
  output logic        sys_rd
);

  typedef enum logic [2:0] {SYNC, IDLE, FETCH, MEMRW, IOCYC, INTACK} state_t;

  state_t     state_q, state_d;
  logic       on_q, on_d;
  logic       off_q, off_d;
  logic       vg_q, vg_d;
  logic [1:0] vg_a_q, vg_a_d;
  logic       sys_wr_q, sys_wr_d;
  logic       sys_rd_q, sys_rd_d;

  logic enter_fetch, enter_io, fetch_off, vg_hit;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
      vg_q     <= 1'b0;
      vg_a_q   <= 2'b00;
      sys_wr_q <= 1'b0;
      sys_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      off_q    <= off_d;
      vg_q     <= vg_d;
      vg_a_q   <= vg_a_d;
      sys_wr_q <= sys_wr_d;
      sys_rd_q <= sys_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (zpos) begin
      case (state_q)
        // Wait for a bus gap so a cycle already underway at reset release is never classified.
        SYNC:   if (mreq_n && iorq_n) state_d = IDLE;
        IDLE: begin
          if (!m1_n && !iorq_n)                 state_d = INTACK;
          else if (!m1_n && !mreq_n && !rd_n)   state_d = FETCH;
          else if (!mreq_n)                     state_d = MEMRW;
          else if (!iorq_n && (!rd_n || !wr_n)) state_d = IOCYC;
        end
        FETCH, MEMRW:  if (mreq_n) state_d = IDLE;
        IOCYC, INTACK: if (iorq_n) state_d = IDLE;
        default:       state_d = SYNC;
      endcase
    end
  end

  always_comb begin
    on_d     = 1'b0;
    off_d    = 1'b0;
    vg_d     = 1'b0;
    vg_a_d   = vg_a_q;
    sys_wr_d = 1'b0;
    sys_rd_d = 1'b0;

    enter_fetch = zpos && (state_q == IDLE) && (state_d == FETCH);
    enter_io    = zpos && (state_q == IDLE) && (state_d == IOCYC);
    fetch_off   = dos && (a[15:14] != 2'b00);
    vg_hit      = !a[7] && (a[4:0] == 5'h1F);

    if (enter_fetch) begin
      off_d = fetch_off;
      // Exit wins if TRAP_HI is ever moved into the upper 48K.
      on_d  = !dos && trap_en && romnram && rom_basic && (a[15:8] == TRAP_HI) && !fetch_off;
    end

    if (enter_io && dos) begin
      if (vg_hit) begin
        vg_d   = 1'b1;
        vg_a_d = a[6:5];
      end
      if (a[7:0] == SYS_PORT) begin
        sys_wr_d = !wr_n;
        sys_rd_d = wr_n;
      end
    end
  end

  assign dos_turn_on  = on_q;
  assign dos_turn_off = off_q;
  assign vg_rdwr_fclk = vg_q;
  assign vg_a         = vg_a_q;
  assign sys_wr       = sys_wr_q;
  assign sys_rd       = sys_rd_q;

endmodule

// File: tb/tb_zdos_trap.sv
// tb/tb_zdos_trap.sv - directed self-checking bench for zdos_trap.
module tb_zdos_trap;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        zpos;
  logic [15:0] a;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic        dos, romnram, rom_basic, trap_en;
  logic        dos_turn_on, dos_turn_off, vg_rdwr_fclk, sys_wr, sys_rd;
  logic [1:0]  vg_a;

  int checks = 0;
  int failures = 0;
  int n_on = 0, n_off = 0, n_vg = 0, n_wr = 0, n_rd = 0;

  zdos_trap dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .a(a),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .dos(dos), .romnram(romnram), .rom_basic(rom_basic), .trap_en(trap_en),
    .dos_turn_on(dos_turn_on), .dos_turn_off(dos_turn_off),
    .vg_rdwr_fclk(vg_rdwr_fclk), .vg_a(vg_a), .sys_wr(sys_wr), .sys_rd(sys_rd)
  );

  always #5 fclk = ~fclk;

  // Pulse counters sampled mid-cycle: a one-fclk pulse is seen exactly once.
  always @(negedge fclk) begin
    if (dos_turn_on)  n_on++;
    if (dos_turn_off) n_off++;
    if (vg_rdwr_fclk) n_vg++;
    if (sys_wr)       n_wr++;
    if (sys_rd)       n_rd++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ztick();
    zpos = 1'b1;
    @(posedge fclk); #1;
    zpos = 1'b0;
    repeat (3) @(posedge fclk);
    #1;
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    ztick();
    ztick();
  endtask

  task automatic fetch(input logic [15:0] addr, input int n);
    a = addr; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (n) ztick();
    bus_idle();
  endtask

  task automatic io(input logic [15:0] addr, input logic rd, input logic wr);
    a = addr; iorq_n = 1'b0; rd_n = rd; wr_n = wr;
    ztick();
    ztick();
    bus_idle();
  endtask

  initial begin
    rst_n = 1'b0; zpos = 1'b0; a = 16'h3D2F;
    m1_n = 1'b0; mreq_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    dos = 1'b0; romnram = 1'b1; rom_basic = 1'b1; trap_en = 1'b1;
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_on", dos_turn_on, 0);
    chk("rst_off", dos_turn_off, 0);
    chk("rst_vg", vg_rdwr_fclk, 0);
    chk("rst_vga", vg_a, 0);
    chk("rst_syswr", sys_wr, 0);
    chk("rst_sysrd", sys_rd, 0);

    // Release mid-fetch: the in-progress cycle must be discarded.
    rst_n = 1'b1;
    ztick();
    ztick();
    bus_idle();
    chk("sync_no_on", n_on, 0);

    // Fresh trap fetch with exact latency/width check.
    a = 16'h3D2F; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    zpos = 1'b1;
    @(posedge fclk); #1;
    chk("on_latency", dos_turn_on, 1);
    zpos = 1'b0;
    @(posedge fclk); #1;
    chk("on_width", dos_turn_on, 0);
    repeat (2) @(posedge fclk);
    #1;
    ztick();
    bus_idle();
    chk("on_count", n_on, 1);

    dos = 1'b1;
    fetch(16'h8000, 4);
    chk("off_waitst", n_off, 1);
    fetch(16'h3FFF, 2);
    chk("off_low16k", n_off, 1);
    chk("on_dos1", n_on, 1);

    io(16'h005F, 1'b1, 1'b0);
    chk("vg_cnt_5f", n_vg, 1);
    chk("vg_a_5f", vg_a, 2'b10);
    io(16'h00FF, 1'b0, 1'b1);
    chk("sysrd_cnt", n_rd, 1);
    chk("sysrd_nowr", n_wr, 0);
    chk("vga_keep_ff", vg_a, 2'b10);
    io(16'h00FF, 1'b1, 1'b0);
    chk("syswr_cnt", n_wr, 1);
    io(16'h00FF, 1'b0, 1'b0);
    chk("rdwr_is_wr", n_wr, 2);
    chk("rdwr_no_rd", n_rd, 1);
    io(16'hAB7F, 1'b0, 1'b1);
    chk("vg_cnt_7f", n_vg, 2);
    chk("vg_a_7f", vg_a, 2'b11);

    dos = 1'b0;
    io(16'h001F, 1'b0, 1'b1);
    io(16'h00FF, 1'b1, 1'b0);
    chk("dos0_vg", n_vg, 2);
    chk("dos0_wr", n_wr, 2);
    chk("dos0_rd", n_rd, 1);
    chk("dos0_vga", vg_a, 2'b11);

    // Interrupt acknowledge, then a non-M1 memory read at the trap address.
    a = 16'h3D00; m1_n = 1'b0; iorq_n = 1'b0;
    ztick();
    ztick();
    bus_idle();
    a = 16'h3D00; mreq_n = 1'b0; rd_n = 1'b0;
    ztick();
    bus_idle();
    chk("intack_mem_on", n_on, 1);
    chk("intack_mem_vg", n_vg, 2);

    rom_basic = 1'b0;
    fetch(16'h3D00, 1);
    chk("gate_basic", n_on, 1);
    rom_basic = 1'b1; trap_en = 1'b0;
    fetch(16'h3D00, 1);
    chk("gate_trapen", n_on, 1);
    trap_en = 1'b1;
    fetch(16'h3D00, 1);
    chk("gate_open", n_on, 2);

    // Async reset while a pulse is live and the fetch still open.
    a = 16'h3D00; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    zpos = 1'b1;
    @(posedge fclk); #1;
    zpos = 1'b0;
    chk("pre_rst_on", dos_turn_on, 1);
    rst_n = 1'b0;
    #1;
    chk("async_on", dos_turn_on, 0);
    chk("async_vga", vg_a, 0);
    @(posedge fclk); #1;
    rst_n = 1'b1;
    ztick();
    ztick();
    chk("resync_no_on", n_on, 2);
    bus_idle();
    fetch(16'h3D00, 1);
    chk("after_resync_on", n_on, 3);
    chk("final_off", n_off, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zdos_trap.md
Name: zdos_trap

Overview:
- Bus-cycle observer that sits directly upstream of the DOS/TR-DOS-emulation control block.
- Watches the Z80 bus, already sampled into the fclk domain, and classifies each bus cycle once.
- Produces the single-fclk strobes that control the DOS signal: dos_turn_on and dos_turn_off.
- Also produces the VG93 port-access strobe with its register index (vg_rdwr_fclk, vg_a) and the system-port strobes.

Parameters:
- TRAP_HI, 8'h3D: high address byte of the M1 fetch that enters DOS.
- SYS_PORT, 8'hFF: low address byte of the DOS system port.

Ports:
- fclk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- zpos  in  1  one-fclk strobe marking the Z80 clock rising edge; all bus sampling happens only when zpos=1.
- a  in  16  Z80 address.
- m1_n, mreq_n, iorq_n, rd_n, wr_n  in  1 each  Z80 strobes, already synchronous to fclk.
- dos  in  1  current DOS state, fed back from the DOS control block.
- romnram  in  1  window 0 is mapped to ROM.
- rom_basic  in  1  the selected ROM page is 48K BASIC.
- trap_en  in  1  enables the DOS entry trap.
- dos_turn_on  out  1  one-fclk pulse.
- dos_turn_off  out  1  one-fclk pulse.
- vg_rdwr_fclk  out  1  one-fclk pulse on a VG93 register access.
- vg_a  out  2  VG93 register index, held until the next VG access.
- sys_wr, sys_rd  out  1 each  one-fclk pulses on a system-port access.

Behaviour:
- Reset values: all pulse outputs 0, vg_a=2'b00, FSM in state SYNC.
- FSM states: SYNC, IDLE, FETCH, MEMRW, IOCYC, INTACK. The FSM advances only on fclk edges where zpos=1.
- SYNC: go to IDLE at the first zpos sample with mreq_n=1 and iorq_n=1. This discards any bus cycle that was already in progress when reset was released, whether reset was applied mid-cycle or released mid-cycle.
- IDLE, at zpos, first match wins:
  - m1_n=0 & iorq_n=0 -> INTACK.
  - m1_n=0 & mreq_n=0 & rd_n=0 -> FETCH.
  - mreq_n=0 -> MEMRW.
  - iorq_n=0 & (rd_n=0 | wr_n=0) -> IOCYC.
  - otherwise stay in IDLE.
- All decisions are evaluated on the IDLE->x transition, using the values sampled on that edge. Each pulse is registered and asserted for exactly the following fclk cycle. Latency is 1 fclk after the qualifying zpos. At most one classification is made per bus cycle.
- Fetch decisions (entering FETCH):
  - on = !dos & trap_en & romnram & rom_basic & a[15:8]==TRAP_HI.
  - off = dos & a[15:14]!=2'b00.
  - on and off are mutually exclusive by construction, because TRAP_HI lies below 8'h40.
  - If the TRAP_HI parameter is overridden to a value of 8'h40 or above, off takes priority and on is suppressed.
- IO decisions (entering IOCYC, only when dos=1):
  - a[7:0] in {1F,3F,5F,7F}: pulse vg_rdwr_fclk and load vg_a <= a[6:5]. A value of a[6:5] is accepted regardless of a[15:8].
  - a[7:0]==SYS_PORT: pulse sys_wr if wr_n=0, else pulse sys_rd.
  - If rd_n=0 and wr_n=0 are both sampled low, treat the access as a write.
  - When dos=0, IO cycles produce no strobes.
- FETCH, MEMRW, IOCYC and INTACK each return to IDLE at the first zpos sample where the strobe that opened the state has gone high. That strobe is mreq_n for FETCH and MEMRW, and iorq_n for IOCYC and INTACK. No new cycle is recognised on that same edge; the next cycle is earliest at the following zpos.
- A wait-stated cycle, i.e. one that stays in its state for many zpos edges, still produces exactly one pulse.
- The dos input can change as a result of our own pulse one fclk later. The FSM must not re-evaluate until the next IDLE transition.
- Interrupt acknowledge cycles (INTACK) and plain memory read/write cycles (MEMRW) never produce any strobe.
- zpos=0 on every edge: the FSM and vg_a are frozen, and the pulse outputs return to 0.

Test Plan:
- Reset, then release rst_n while mreq_n=0 and m1_n=0 with a=16'h3D2F -> no dos_turn_on. Then a fresh fetch at 16'h3D2F with dos=0, romnram=1, rom_basic=1, trap_en=1 -> exactly one dos_turn_on, 1 fclk wide, 1 fclk after the zpos edge.
- dos=1, M1 fetch at 16'h8000 held for 4 zpos edges (wait states) -> exactly one dos_turn_off. Same fetch at 16'h3FFF -> no pulse.
- dos=1, IO write to 16'h005F -> vg_rdwr_fclk one pulse and vg_a=2'b10. IO read of 16'h00FF -> sys_rd pulse, and vg_a unchanged at 2'b10.
- dos=0, IO access to 16'h001F and 16'h00FF -> no strobes, vg_a unchanged.
- Interrupt acknowledge (m1_n=0, iorq_n=0, a=16'h3D00, dos=0) -> no strobes. A memory read (m1_n=1) at 16'h3D00 -> no dos_turn_on.
- Trap gating: fetch at 16'h3D00 with rom_basic=0 or trap_en=0 -> no pulse. Assert rst_n low mid-FETCH -> all outputs 0 immediately and state SYNC.
